// File: rtl/junction_pkg.sv
// Shared definitions for the junction phase scheduler: lamp codes, the
// phase encoding and default timing parameters.
package junction_pkg;

    localparam logic [1:0] LAMP_RED    = 2'd0;
    localparam logic [1:0] LAMP_YELLOW = 2'd1;
    localparam logic [1:0] LAMP_GREEN  = 2'd2;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'd0,
        PH_YELLOW = 2'd1,
        PH_ALLRED = 2'd2,
        PH_WALK   = 2'd3
    } phase_e;

    localparam int DEF_NUM_APPR    = 4;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_MIN_GREEN   = 3;
    localparam int DEF_MAX_GREEN   = 6;
    localparam int DEF_YELLOW_TIME = 2;
    localparam int DEF_ALLRED_TIME = 1;
    localparam int DEF_WALK_TIME   = 4;

endpackage

// File: rtl/junction_phase_scheduler_rr_pick.sv
// Combinational round-robin finder: first set bit of pending scanning
// cur+1, cur+2, ... with wrap (cur itself is examined last).
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] cur,
    output logic [IDX_W-1:0] next_idx,
    output logic             any
);

    int               idx;
    logic [IDX_W-1:0] idx_sel;

    // Scan from the farthest candidate down to the nearest so the nearest wins.
    always_comb begin
        next_idx = '0;
        idx      = 0;
        idx_sel  = '0;
        for (int k = N; k >= 1; k--) begin
            idx = int'(cur) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_sel = IDX_W'(idx);
            if (pending[idx_sel]) begin
                next_idx = idx_sel;
            end
        end
        any = |pending;
    end

endmodule

// File: rtl/junction_phase_scheduler.sv
// Multi-approach junction phase scheduler. Latches sensor requests, serves
// approaches round-robin through GREEN -> YELLOW -> ALLRED with tick-based
// min/max green timing. Optional pedestrian WALK phase under PED_CROSSING_EN.
module junction_phase_scheduler
    import junction_pkg::*;
#(
    parameter int NUM_APPR    = DEF_NUM_APPR,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MIN_GREEN   = DEF_MIN_GREEN,
    parameter int MAX_GREEN   = DEF_MAX_GREEN,
    parameter int YELLOW_TIME = DEF_YELLOW_TIME,
    parameter int ALLRED_TIME = DEF_ALLRED_TIME,
    parameter int WALK_TIME   = DEF_WALK_TIME
) (
    input  logic                        clock,
    input  logic                        clear,
    input  logic                        tick,
    input  logic [NUM_APPR-1:0]         req,
`ifdef PED_CROSSING_EN
    input  logic                        ped_req,
    output logic                        walk,
`endif
    output logic [2*NUM_APPR-1:0]       sig,
    output logic [$clog2(NUM_APPR)-1:0] cur_appr,
    output logic [1:0]                  phase
);

    localparam int IDX_W = $clog2(NUM_APPR);
    localparam logic [CNT_W:0] MIN_G = (CNT_W+1)'(MIN_GREEN);
    localparam logic [CNT_W:0] MAX_G = (CNT_W+1)'(MAX_GREEN);
    localparam logic [CNT_W:0] YEL_T = (CNT_W+1)'(YELLOW_TIME);
    localparam logic [CNT_W:0] AR_T  = (CNT_W+1)'(ALLRED_TIME);

    phase_e                phase_q, phase_d;
    logic [IDX_W-1:0]      cur_q, cur_d;
    logic [CNT_W-1:0]      timer_q, timer_d;
    logic [NUM_APPR-1:0]   pending_q, pending_d;
    logic [2*NUM_APPR-1:0] sig_q, sig_d;
    logic [CNT_W:0]        e;
    logic [NUM_APPR-1:0]   cur_onehot, next_onehot;
    logic [IDX_W-1:0]      rr_idx;
    logic                  rr_any, demand, req_cur, enter_green;
`ifdef PED_CROSSING_EN
    localparam logic [CNT_W:0] WALK_T = (CNT_W+1)'(WALK_TIME);
    logic ped_pend_q, ped_pend_d, walk_q, walk_d, ped_clr;
`endif

    rr_pick #(.N(NUM_APPR), .IDX_W(IDX_W)) u_rr_pick (
        .pending  (pending_q),
        .cur      (cur_q),
        .next_idx (rr_idx),
        .any      (rr_any)
    );

    // One-hot views of the current and next owner, and per-approach lamp codes.
    for (genvar gi = 0; gi < NUM_APPR; gi++) begin : g_appr
        assign cur_onehot[gi]  = (cur_q == IDX_W'(gi));
        assign next_onehot[gi] = (cur_d == IDX_W'(gi));
        assign sig_d[2*gi +: 2] =
            (next_onehot[gi] && phase_d == PH_GREEN)  ? LAMP_GREEN  :
            (next_onehot[gi] && phase_d == PH_YELLOW) ? LAMP_YELLOW : LAMP_RED;
    end

    assign e       = {1'b0, timer_q} + 1'b1;
    assign req_cur = |(req & cur_onehot);
`ifdef PED_CROSSING_EN
    assign demand  = (|(pending_q & ~cur_onehot)) | ped_pend_q;
`else
    assign demand  = |(pending_q & ~cur_onehot);
`endif

    // Phase sequencing and phase timer.
    always_comb begin
        phase_d     = phase_q;
        cur_d       = cur_q;
        timer_d     = timer_q;
        enter_green = 1'b0;
`ifdef PED_CROSSING_EN
        ped_clr     = 1'b0;
`endif
        case (phase_q)
            PH_GREEN: begin
                if (tick) begin
                    if (e >= MIN_G && demand && (!req_cur || e >= MAX_G)) begin
                        phase_d = PH_YELLOW;
                        timer_d = '0;
                    end else begin
                        timer_d = (e >= MAX_G) ? MAX_G[CNT_W-1:0] : e[CNT_W-1:0];
                    end
                end
            end
            PH_YELLOW: begin
                if (tick) begin
                    if (e == YEL_T) begin
                        phase_d = PH_ALLRED;
                        timer_d = '0;
                    end else begin
                        timer_d = e[CNT_W-1:0];
                    end
                end
            end
            PH_ALLRED: begin
                if (tick) begin
                    if (e == AR_T) begin
                        timer_d = '0;
`ifdef PED_CROSSING_EN
                        if (ped_pend_q) begin
                            phase_d = PH_WALK;
                            ped_clr = 1'b1;
                        end else
`endif
                        begin
                            phase_d     = PH_GREEN;
                            enter_green = 1'b1;
                            if (rr_any) cur_d = rr_idx;
                        end
                    end else begin
                        timer_d = e[CNT_W-1:0];
                    end
                end
            end
`ifdef PED_CROSSING_EN
            PH_WALK: begin
                if (tick) begin
                    if (e == WALK_T) begin
                        timer_d     = '0;
                        phase_d     = PH_GREEN;
                        enter_green = 1'b1;
                        if (rr_any) cur_d = rr_idx;
                    end else begin
                        timer_d = e[CNT_W-1:0];
                    end
                end
            end
`endif
            default: begin
                phase_d = PH_ALLRED;
                timer_d = '0;
            end
        endcase
    end

    // Request latching: the green owner does not re-latch itself; entry clears.
    always_comb begin
        pending_d = (pending_q | (req & ~((phase_q == PH_GREEN) ? cur_onehot : '0)))
                  & ~(enter_green ? next_onehot : '0);
`ifdef PED_CROSSING_EN
        ped_pend_d = (ped_pend_q | ped_req) & ~ped_clr;
        walk_d     = (phase_d == PH_WALK);
`endif
    end

    // State and registered outputs; clear overrides everything including tick.
    always_ff @(posedge clock) begin
        if (clear) begin
            phase_q   <= PH_GREEN;
            cur_q     <= '0;
            timer_q   <= '0;
            pending_q <= '0;
            sig_q     <= (2*NUM_APPR)'(LAMP_GREEN);
`ifdef PED_CROSSING_EN
            ped_pend_q <= 1'b0;
            walk_q     <= 1'b0;
`endif
        end else begin
            phase_q   <= phase_d;
            cur_q     <= cur_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            sig_q     <= sig_d;
`ifdef PED_CROSSING_EN
            ped_pend_q <= ped_pend_d;
            walk_q     <= walk_d;
`endif
        end
    end

    assign sig      = sig_q;
    assign cur_appr = cur_q;
    assign phase    = phase_q;
`ifdef PED_CROSSING_EN
    assign walk     = walk_q;
`endif

endmodule

// File: tb/tb_junction_phase_scheduler.sv
// Scoreboard bench for junction_phase_scheduler (default parameters).
// The driver pushes the expected post-edge (phase, cur_appr) for each cycle;
// the monitor pops and compares sig/phase/cur_appr (and walk with
// PED_CROSSING_EN) one cycle at a time, 1 time unit after each rising edge.
module tb_junction_phase_scheduler;

    logic       clock;
    logic       clear;
    logic       tick;
    logic [3:0] req;
    logic       ped_req;
    logic [7:0] sig;
    logic [1:0] cur_appr;
    logic [1:0] phase;
    logic       walk;

    typedef struct {
        logic [1:0] ph;
        logic [1:0] cu;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    localparam logic [1:0] G = 2'd0, Y = 2'd1, A = 2'd2, W = 2'd3;

    junction_phase_scheduler dut (
        .clock    (clock),
        .clear    (clear),
        .tick     (tick),
        .req      (req),
`ifdef PED_CROSSING_EN
        .ped_req  (ped_req),
        .walk     (walk),
`endif
        .sig      (sig),
        .cur_appr (cur_appr),
        .phase    (phase)
    );

`ifndef PED_CROSSING_EN
    assign walk = 1'b0;
`endif

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] lamps(input logic [1:0] ph, input logic [1:0] cu);
        logic [7:0] v;
        v = '0;
        if (ph == G) v[2*cu +: 2] = 2'd2;
        else if (ph == Y) v[2*cu +: 2] = 2'd1;
        return v;
    endfunction

    // Monitor: one transaction per clock once expectations are queued.
    initial begin
        exp_t x;
        logic [7:0] es;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                x  = exp_q.pop_front();
                es = lamps(x.ph, x.cu);
                txn++;
                checks += 3;
                if (sig !== es) begin
                    errors++;
                    $display("FAIL %s#%0d sig got %b want %b", x.tag, txn, sig, es);
                end
                if (phase !== x.ph) begin
                    errors++;
                    $display("FAIL %s#%0d phase got %0d want %0d", x.tag, txn, phase, x.ph);
                end
                if (cur_appr !== x.cu) begin
                    errors++;
                    $display("FAIL %s#%0d cur_appr got %0d want %0d", x.tag, txn, cur_appr, x.cu);
                end
`ifdef PED_CROSSING_EN
                checks++;
                if (walk !== (x.ph == W)) begin
                    errors++;
                    $display("FAIL %s#%0d walk got %b want %b", x.tag, txn, walk, (x.ph == W));
                end
`endif
                $display("txn %0d %s sig=%b phase=%0d cur=%0d walk=%b", txn, x.tag, sig, phase, cur_appr, walk);
            end
        end
    end

    // Drive one cycle and queue the expected state after the coming edge.
    task automatic cyc(input logic [3:0] r, input logic t, input logic c, input logic pr,
                       input logic [1:0] ph, input logic [1:0] cu, input string tag);
        exp_t x;
        @(negedge clock);
        req     = r;
        tick    = t;
        clear   = c;
        ped_req = pr;
        x.ph  = ph;
        x.cu  = cu;
        x.tag = tag;
        exp_q.push_back(x);
    endtask

    task automatic run(input int n, input logic [3:0] r, input logic [1:0] ph,
                       input logic [1:0] cu, input string tag);
        for (int i = 0; i < n; i++) cyc(r, 1'b1, 1'b0, 1'b0, ph, cu, tag);
    endtask

    task automatic do_clear(input string tag);
        cyc(4'b0000, 1'b1, 1'b1, 1'b0, G, 2'd0, tag);
    endtask

    initial begin
        req = '0; tick = 1'b0; clear = 1'b0; ped_req = 1'b0;

        // Reset then idle: approach 0 green forever.
        cyc(4'b0000, 1'b0, 1'b1, 1'b0, G, 2'd0, "rst");
        run(20, 4'b0000, G, 2'd0, "idle");

        // Single pulse on req[2].
        do_clear("pulse");
        run(1, 4'b0100, G, 2'd0, "pulse");
        run(1, 4'b0000, G, 2'd0, "pulse");
        run(2, 4'b0000, Y, 2'd0, "pulse");
        run(1, 4'b0000, A, 2'd0, "pulse");
        run(2, 4'b0000, G, 2'd2, "pulse");

        // req[0] held, req[1] pulsed: max green cap.
        do_clear("maxg");
        run(1, 4'b0011, G, 2'd0, "maxg");
        run(4, 4'b0001, G, 2'd0, "maxg");
        run(1, 4'b0001, Y, 2'd0, "maxg");
        run(1, 4'b0000, Y, 2'd0, "maxg");
        run(1, 4'b0000, A, 2'd0, "maxg");
        run(2, 4'b0000, G, 2'd1, "maxg");

        // Round-robin order 1, 3, then 0.
        do_clear("rr");
        run(1, 4'b1010, G, 2'd0, "rr");
        run(1, 4'b0000, G, 2'd0, "rr");
        run(2, 4'b0000, Y, 2'd0, "rr");
        run(1, 4'b0000, A, 2'd0, "rr");
        run(1, 4'b0000, G, 2'd1, "rr");
        run(1, 4'b0001, G, 2'd1, "rr");
        run(1, 4'b0000, G, 2'd1, "rr");
        run(2, 4'b0000, Y, 2'd1, "rr");
        run(1, 4'b0000, A, 2'd1, "rr");
        run(3, 4'b0000, G, 2'd3, "rr");
        run(2, 4'b0000, Y, 2'd3, "rr");
        run(1, 4'b0000, A, 2'd3, "rr");
        run(2, 4'b0000, G, 2'd0, "rr");

        // Clear mid-yellow drops the pending request.
        do_clear("clr");
        run(1, 4'b0100, G, 2'd0, "clr");
        run(1, 4'b0000, G, 2'd0, "clr");
        run(2, 4'b0000, Y, 2'd0, "clr");
        cyc(4'b0000, 1'b1, 1'b1, 1'b0, G, 2'd0, "clr");
        run(5, 4'b0000, G, 2'd0, "clr");
        run(1, 4'b0100, G, 2'd0, "clr");
        run(2, 4'b0000, Y, 2'd0, "clr");
        run(1, 4'b0000, A, 2'd0, "clr");
        run(1, 4'b0000, G, 2'd2, "clr");

        // Tick every 4th cycle: durations x4; clear with tick low.
        cyc(4'b0000, 1'b0, 1'b1, 1'b0, G, 2'd0, "tick4");
        for (int k = 1; k <= 26; k++) begin
            logic [1:0] eph;
            logic [1:0] ecu;
            if (k < 12)      begin eph = G; ecu = 2'd0; end
            else if (k < 20) begin eph = Y; ecu = 2'd0; end
            else if (k < 24) begin eph = A; ecu = 2'd0; end
            else             begin eph = G; ecu = 2'd1; end
            cyc((k == 1) ? 4'b0010 : 4'b0000, (k % 4 == 0), 1'b0, 1'b0, eph, ecu, "tick4");
        end

`ifdef PED_CROSSING_EN
        // Pedestrian request: WALK after ALLRED, then approach 0 again.
        do_clear("ped");
        cyc(4'b0000, 1'b1, 1'b0, 1'b1, G, 2'd0, "ped");
        run(1, 4'b0000, G, 2'd0, "ped");
        run(2, 4'b0000, Y, 2'd0, "ped");
        run(1, 4'b0000, A, 2'd0, "ped");
        run(4, 4'b0000, W, 2'd0, "ped");
        run(2, 4'b0000, G, 2'd0, "ped");
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/junction_phase_scheduler.md
# junction_phase_scheduler

Multi-approach phase scheduler for a signalised junction. It generalises the two-road highway/country controller to NUM_APPR approaches. Latched vehicle-sensor requests are arbitrated round-robin, and one approach at a time is sequenced through GREEN → YELLOW → ALL-RED with tick-based minimum/maximum green timing. It sits between the road sensors and the lamp drivers, and a shared timebase supplies the `tick` strobe.

## Interface
- NUM_APPR, 4: number of approaches (2..8)
- CNT_W, 8: phase timer width; every time parameter must be < 2**CNT_W
- MIN_GREEN, 3: minimum green, in ticks (≥1)
- MAX_GREEN, 6: maximum green under contention, in ticks (≥MIN_GREEN)
- YELLOW_TIME, 2: yellow duration, in ticks (≥1)
- ALLRED_TIME, 1: all-red clearance, in ticks (≥1)
- WALK_TIME, 4: pedestrian walk duration, in ticks (only with PED_CROSSING_EN)

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- clear  in  1  synchronous, active-high reset
- tick  in  1  one-cycle timebase strobe; timers advance only on cycles where tick=1
- req  in  NUM_APPR  vehicle present on approach i (level)
- ped_req  in  1  pedestrian button, level or pulse (only with PED_CROSSING_EN)
- sig  out  2*NUM_APPR  lamp code of approach i at sig[2i+1:2i]: RED=0, YELLOW=1, GREEN=2
- cur_appr  out  $clog2(NUM_APPR)  approach currently owning the phase
- phase  out  2  GREEN=0, YELLOW=1, ALLRED=2, WALK=3
- walk  out  1  pedestrian WALK lamp (only with PED_CROSSING_EN)

## Operation
- Reset values: phase=GREEN, cur_appr=0, sig = approach 0 GREEN and all others RED, walk=0, pending=0, timer=0.
- pending[i] is set on any cycle where req[i]=1, except when i==cur_appr and phase==GREEN. It is cleared on the cycle approach i enters GREEN. A set and a clear in the same cycle resolve to clear.
- timer clears on every phase entry, increments on tick, and saturates at MAX_GREEN while in GREEN. Define e = timer+1, the tick count including the current tick.
- GREEN exits to YELLOW on a tick cycle when all of the following hold:
  - e ≥ MIN_GREEN;
  - some other pending bit is set, or the pedestrian request is latched;
  - req[cur_appr]=0, or e ≥ MAX_GREEN.
- With no competing demand, GREEN is held indefinitely and there is no gap-out.
- YELLOW exits to ALLRED on the tick cycle where e == YELLOW_TIME.
- ALLRED exits on the tick cycle where e == ALLRED_TIME:
  - cur_appr ← first pending index scanning cur_appr+1, cur_appr+2, … with wrap;
  - that approach enters GREEN;
  - if none is pending, cur_appr is unchanged and the same approach re-enters GREEN.
- During YELLOW only cur_appr shows YELLOW, and all other approaches show RED. ALLRED shows all RED.
- An illegal phase encoding recovers to ALLRED with timer=0.

## Timing
- Outputs are registered. sig, phase and cur_appr change on the edge where the transition condition is met, so they reflect the new phase in the following cycle.
- With tick tied high: YELLOW lasts exactly YELLOW_TIME cycles and ALLRED exactly ALLRED_TIME cycles. A contested green lasts max(MIN_GREEN, demand-drop) cycles, capped at MAX_GREEN.
- Requests need only be high for one cycle; they are captured into pending.
- clear asserted in any phase, including mid-YELLOW or mid-WALK, restores the reset values on the next edge, regardless of tick. clear has priority over tick.

## Configuration
- PED_CROSSING_EN defined:
  - adds the ped_req and walk ports, a sticky ped_pend flag, and the WALK phase.
  - ped_pend counts as competing demand for the GREEN exit.
  - at ALLRED exit ped_pend has priority: the block enters WALK (all RED, walk=1) for WALK_TIME ticks and clears ped_pend.
  - WALK is followed by GREEN of the round-robin selection.
- Undefined: no ped ports and no WALK state; phase never equals 3.

## Structure
- Shared package `junction_pkg`:
  - lamp codes RED/YELLOW/GREEN;
  - phase encoding typedef;
  - time-parameter defaults.
- One sub-module, `rr_pick`: combinational round-robin first-set finder taking (pending, cur_appr) and producing (next_idx, any). It is instantiated once.

## Test plan
All scenarios use default parameters and tick=1 every cycle unless stated.
- Reset, req=0 for 20 cycles → sig=8'b00_00_00_10 throughout, phase=GREEN, cur_appr=0.
- One-cycle pulse on req[2] with req[0]=0 → approach 0 GREEN for 3 cycles, then YELLOW for 2 cycles, then all RED for 1 cycle, then sig[5:4]=GREEN and cur_appr=2.
- req[0] held high with req[1] pulsed → approach 0 stays GREEN for exactly 6 cycles (MAX_GREEN), then YELLOW; approach 1 is served next.
- req[1] and req[3] pulsed together while approach 0 is GREEN → green order is 1, then 3. A req[0] pulse during approach 1's green is served after 3.
- clear asserted on the 2nd cycle of YELLOW → next cycle sig=8'b00_00_00_10, pending=0; a previously pending approach is not served until it requests again.
- Tick every 4th cycle → all phase durations scale ×4. With PED_CROSSING_EN, ped_req pulsed during approach 0 GREEN → after ALLRED, walk=1 with all RED for 4 ticks, then approach 0 re-enters GREEN because nothing else is pending.
